uart_verici: RTL and testbench
==============================

Name: uart_verici

Overview:
- Serial UART transmitter used inside uart_denetleyicisi; drains the TX FIFO through a valid/ready handshake and drives tx_o.
- Frame format: one start bit, 8 data bits LSB-first, optional even/odd parity bit, then 1 or 2 stop bits.
- Bit period comes from the controller's divider register.
- Frame configuration is latched once per byte at accept time.

Parameters:
- VERI_BIT, 8, data bits per frame.
- BOLUCU_BIT, 16, width of the bit-period divider input.

Ports:
- clk_i  input  1  system clock.
- rstn_i  input  1  asynchronous active-low reset.
- veri_i  input  VERI_BIT  byte to transmit, from the TX FIFO head.
- gecerli_i  input  1  veri_i valid.
- hazir_o  output  1  transmitter can accept a byte.
- tx_en_i  input  1  transmit enable from the control register.
- bolucu_i  input  BOLUCU_BIT  clock cycles per bit; 0 and 1 both mean 1 cycle.
- parite_en_i  input  1  append a parity bit.
- parite_tek_i  input  1  1 = odd parity, 0 = even parity.
- dur_iki_i  input  1  1 = two stop bits, 0 = one.
- tx_o  output  1  serial line; idles high.
- mesgul_o  output  1  a frame is in progress.
- tamam_o  output  1  one-cycle pulse in the final clock of the final stop bit.

Behaviour:
- Reset (asynchronous, active-low):
  - State BOSTA; tx_o=1, hazir_o=0, mesgul_o=0, tamam_o=0.
  - All counters and shift register cleared.
  - Asserting reset mid-frame forces tx_o high immediately. Frame is abandoned; there is no resume.
- Handshake:
  - Accept happens on a rising edge with gecerli_i && hazir_o.
  - The source holds veri_i stable while gecerli_i=1. It may drop gecerli_i without an accept.
  - hazir_o = tx_en_i && (state==BOSTA || final cycle of final stop bit).
- Latching at accept:
  - veri_i loads into the shift register.
  - bolucu_i, parite_en_i, parite_tek_i and dur_iki_i are captured.
  - Changes to these inputs mid-frame have no effect.
- Period: P = max(bolucu_i, 1) cycles. A bit counter counts 0..P-1 and wraps; the bit advances on wrap.
- States and transitions:
  - BOSTA: tx_o=1. On accept -> BASLA.
  - BASLA: tx_o=0 for P cycles -> VERI.
  - VERI: tx_o = shift[0] for P cycles per bit; shift right after each bit. After 8 bits -> PARITE if enabled, else DUR.
  - PARITE: tx_o = XOR(data) for even, ~XOR(data) for odd, for P cycles -> DUR.
  - DUR: tx_o=1 for P cycles (2P if two stop bits). At the end, return to BOSTA, or go straight to BASLA if an accept occurred in that final cycle.
- Latency: accept on edge N gives tx_o=0 from cycle N+1.
- Frame length: (10 + parite_en + dur_iki) × P cycles.
- Back-to-back: an accept in the final stop cycle starts the next start bit on the following cycle, with zero idle gap.
- tx_en_i deasserted mid-frame: the current frame completes; no new accept afterwards.
- Outputs during a frame:
  - mesgul_o = (state != BOSTA).
  - tamam_o pulses even when a back-to-back accept occurs in the same cycle.
- tx_o is driven from a register, so the line is glitch-free.

Decomposition:
- sabitler.vh holds:
  - UART state encodings: UART_TX_BOSTA, UART_TX_BASLA, UART_TX_VERI, UART_TX_PARITE, UART_TX_DUR.
  - UART_VERI_BIT=8.
  - Control-register bit positions for tx_en, parite_en, parite_tek, dur_iki and the divider field.
- Sub-module uart_baud_sayaci: divider counter with load/clear and a wrap pulse. It is reused by the future uart_alici.

Test Plan:
- 0x55, bolucu=4, no parity, 1 stop:
  - tx_o over 40 cycles is 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles.
  - tamam_o pulses at cycle 40; hazir_o=1 at cycle 41.
- 0x07, bolucu=2, even parity:
  - Parity bit = 1; frame is 22 cycles.
  - Repeat with odd parity: parity bit = 0.
- 0xA5 then 0x3C, gecerli_i held high, bolucu=3, 2 stop bits:
  - No idle cycle between frames; total 72 cycles.
  - Stop bits high for 6 cycles each frame.
  - Exactly two tamam_o pulses.
- bolucu=0 and bolucu=1, 0xFF:
  - Both give 1 cycle per bit and a 10-cycle frame.
  - Waveforms are identical.
- Reset mid-frame, in data bit 3 of 0x00 at bolucu=8:
  - tx_o=1 in the same cycle as rstn_i low.
  - After release: state BOSTA, mesgul_o=0, no tamam_o pulse.
- Mid-frame changes at bolucu=4:
  - Toggle tx_en_i to 0 and change bolucu_i to 10 during the frame.
  - Frame finishes at P=4; hazir_o stays 0 afterwards while tx_en_i=0.

Source files
------------

// File: rtl/uart_verici_pkg.sv
// Shared constants for the UART transmitter and the future receiver:
// state encodings, frame width and control-register field positions.
package uart_verici_pkg;

  typedef enum logic [2:0] {
    UART_TX_BOSTA  = 3'd0,
    UART_TX_BASLA  = 3'd1,
    UART_TX_VERI   = 3'd2,
    UART_TX_PARITE = 3'd3,
    UART_TX_DUR    = 3'd4
  } uart_tx_durum_e;

  localparam int unsigned UART_VERI_BIT = 8;

  // Control register layout in uart_denetleyicisi
  localparam int unsigned CTRL_TX_EN_BIT      = 0;
  localparam int unsigned CTRL_PARITE_EN_BIT  = 1;
  localparam int unsigned CTRL_PARITE_TEK_BIT = 2;
  localparam int unsigned CTRL_DUR_IKI_BIT    = 3;
  localparam int unsigned CTRL_BOLUCU_LSB     = 16;
  localparam int unsigned CTRL_BOLUCU_MSB     = 31;

endpackage

// File: rtl/uart_baud_sayaci.sv
// Bit-period counter: load latches the period and restarts at 0, wrap pulses
// in the last cycle of each period. Shared with the receiver.
module uart_baud_sayaci #(
  parameter int unsigned BOLUCU_BIT = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  yukle_i,
  input  logic                  temizle_i,
  input  logic [BOLUCU_BIT-1:0] bolucu_i,
  input  logic                  sayim_en_i,
  output logic                  sarma_o
);

  logic [BOLUCU_BIT-1:0] son_q;
  logic [BOLUCU_BIT-1:0] sayac_q;

  assign sarma_o = sayim_en_i && (sayac_q == son_q);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      son_q   <= '0;
      sayac_q <= '0;
    end else if (yukle_i) begin
      // Divider values 0 and 1 both mean a one-cycle bit
      son_q   <= (bolucu_i == '0) ? '0 : bolucu_i - BOLUCU_BIT'(1);
      sayac_q <= '0;
    end else if (temizle_i || sarma_o) begin
      sayac_q <= '0;
    end else if (sayim_en_i) begin
      sayac_q <= sayac_q + BOLUCU_BIT'(1);
    end
  end

endmodule

// File: rtl/uart_verici.sv
// UART transmitter: accepts one byte per valid/ready handshake and sends
// start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits.
module uart_verici
  import uart_verici_pkg::*;
#(
  parameter int unsigned VERI_BIT   = UART_VERI_BIT,
  parameter int unsigned BOLUCU_BIT = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [VERI_BIT-1:0]   veri_i,
  input  logic                  gecerli_i,
  output logic                  hazir_o,
  input  logic                  tx_en_i,
  input  logic [BOLUCU_BIT-1:0] bolucu_i,
  input  logic                  parite_en_i,
  input  logic                  parite_tek_i,
  input  logic                  dur_iki_i,
  output logic                  tx_o,
  output logic                  mesgul_o,
  output logic                  tamam_o
);

  localparam int unsigned IDX_W = $clog2(VERI_BIT);

  uart_tx_durum_e      durum_q, durum_d;
  logic [VERI_BIT-1:0] kaydirma_q, kaydirma_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                parite_en_q, parite_en_d;
  logic                parite_bit_q, parite_bit_d;
  logic                dur_iki_q, dur_iki_d;
  logic                tx_q, tx_d;
  logic                baslat_q;
  logic                sarma, kabul, son_dur;

  uart_baud_sayaci #(
    .BOLUCU_BIT(BOLUCU_BIT)
  ) u_baud (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .yukle_i   (kabul),
    .temizle_i (durum_d == UART_TX_BOSTA),
    .bolucu_i  (bolucu_i),
    .sayim_en_i(durum_q != UART_TX_BOSTA),
    .sarma_o   (sarma)
  );

  assign son_dur  = (durum_q == UART_TX_DUR) && sarma && (idx_q == IDX_W'(dur_iki_q));
  // baslat_q keeps ready low until the first clock after reset release
  assign hazir_o  = tx_en_i && baslat_q && ((durum_q == UART_TX_BOSTA) || son_dur);
  assign kabul    = gecerli_i && hazir_o;
  assign tamam_o  = son_dur;
  assign mesgul_o = (durum_q != UART_TX_BOSTA);
  assign tx_o     = tx_q;

  always_comb begin
    durum_d      = durum_q;
    kaydirma_d   = kaydirma_q;
    idx_d        = idx_q;
    parite_en_d  = parite_en_q;
    parite_bit_d = parite_bit_q;
    dur_iki_d    = dur_iki_q;
    unique case (durum_q)
      UART_TX_BOSTA: ;
      UART_TX_BASLA: begin
        if (sarma) begin
          durum_d = UART_TX_VERI;
          idx_d   = '0;
        end
      end
      UART_TX_VERI: begin
        if (sarma) begin
          kaydirma_d = kaydirma_q >> 1;
          idx_d      = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(VERI_BIT - 1)) begin
            durum_d = parite_en_q ? UART_TX_PARITE : UART_TX_DUR;
            idx_d   = '0;
          end
        end
      end
      UART_TX_PARITE: begin
        if (sarma) begin
          durum_d = UART_TX_DUR;
          idx_d   = '0;
        end
      end
      UART_TX_DUR: begin
        if (sarma) begin
          if (idx_q == IDX_W'(dur_iki_q)) durum_d = UART_TX_BOSTA;
          else                            idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: durum_d = UART_TX_BOSTA;
    endcase
    if (kabul) begin
      durum_d      = UART_TX_BASLA;
      kaydirma_d   = veri_i;
      idx_d        = '0;
      parite_en_d  = parite_en_i;
      parite_bit_d = (^veri_i) ^ parite_tek_i;
      dur_iki_d    = dur_iki_i;
    end
  end

  // Line level is registered from the next state so tx_o never glitches
  always_comb begin
    tx_d = 1'b1;
    unique case (durum_d)
      UART_TX_BOSTA:  tx_d = 1'b1;
      UART_TX_BASLA:  tx_d = 1'b0;
      UART_TX_VERI:   tx_d = kaydirma_d[0];
      UART_TX_PARITE: tx_d = parite_bit_d;
      UART_TX_DUR:    tx_d = 1'b1;
      default:        tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q      <= UART_TX_BOSTA;
      kaydirma_q   <= '0;
      idx_q        <= '0;
      parite_en_q  <= 1'b0;
      parite_bit_q <= 1'b0;
      dur_iki_q    <= 1'b0;
      tx_q         <= 1'b1;
      baslat_q     <= 1'b0;
    end else begin
      durum_q      <= durum_d;
      kaydirma_q   <= kaydirma_d;
      idx_q        <= idx_d;
      parite_en_q  <= parite_en_d;
      parite_bit_q <= parite_bit_d;
      dur_iki_q    <= dur_iki_d;
      tx_q         <= tx_d;
      baslat_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_verici.sv
// Directed bench for uart_verici: table of single frames plus hand-written
// back-to-back, mid-frame configuration change and mid-frame reset cases.
module tb_uart_verici;

  logic        clk;
  logic        rstn;
  logic [7:0]  veri;
  logic        gecerli;
  logic        hazir;
  logic        tx_en;
  logic [15:0] bolucu;
  logic        parite_en;
  logic        parite_tek;
  logic        dur_iki;
  logic        tx;
  logic        mesgul;
  logic        tamam;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [7:0]  veri;
    logic [15:0] bolucu;
    logic        pen;
    logic        ptek;
    logic        dur2;
    int          per;
    logic [11:0] bits;  // expected line level per bit slot, slot 0 = start bit
    int          len;
  } vec_t;

  vec_t vecs[6];

  uart_verici u_dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .veri_i      (veri),
    .gecerli_i   (gecerli),
    .hazir_o     (hazir),
    .tx_en_i     (tx_en),
    .bolucu_i    (bolucu),
    .parite_en_i (parite_en),
    .parite_tek_i(parite_tek),
    .dur_iki_i   (dur_iki),
    .tx_o        (tx),
    .mesgul_o    (mesgul),
    .tamam_o     (tamam)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    veri       = v.veri;
    bolucu     = v.bolucu;
    parite_en  = v.pen;
    parite_tek = v.ptek;
    dur_iki    = v.dur2;
    gecerli    = 1'b1;
    #1 chk($sformatf("v%0d_hazir_pre", k), hazir, 1);
    @(posedge clk);
    for (int c = 1; c <= v.len; c++) begin
      @(negedge clk);
      if (c == 1) gecerli = 1'b0;
      chk($sformatf("v%0d_tx_c%0d", k, c), tx, v.bits[(c-1)/v.per]);
      chk($sformatf("v%0d_tamam_c%0d", k, c), tamam, (c == v.len));
      chk($sformatf("v%0d_mesgul_c%0d", k, c), mesgul, 1);
    end
    @(negedge clk);
    chk($sformatf("v%0d_tx_idle", k), tx, 1);
    chk($sformatf("v%0d_mesgul_idle", k), mesgul, 0);
    chk($sformatf("v%0d_hazir_idle", k), hazir, 1);
    chk($sformatf("v%0d_tamam_idle", k), tamam, 0);
  endtask

  initial begin
    int          pulses;
    logic [11:0] bits_a;
    logic [11:0] bits_b;
    logic [11:0] bits_c;

    n_chk  = 0;
    n_fail = 0;
    //            veri   bol    pen   ptek  dur2  per bits     len
    vecs[0] = '{8'h55, 16'd4, 1'b0, 1'b0, 1'b0, 4, 12'h2AA, 40};
    vecs[1] = '{8'h07, 16'd2, 1'b1, 1'b0, 1'b0, 2, 12'h60E, 22};
    vecs[2] = '{8'h07, 16'd2, 1'b1, 1'b1, 1'b0, 2, 12'h40E, 22};
    vecs[3] = '{8'hFF, 16'd0, 1'b0, 1'b0, 1'b0, 1, 12'h3FE, 10};
    vecs[4] = '{8'hFF, 16'd1, 1'b0, 1'b0, 1'b0, 1, 12'h3FE, 10};
    vecs[5] = '{8'h00, 16'd1, 1'b1, 1'b1, 1'b1, 1, 12'hE00, 12};

    rstn = 1'b0; veri = 8'h00; gecerli = 1'b0; tx_en = 1'b1;
    bolucu = 16'd4; parite_en = 1'b0; parite_tek = 1'b0; dur_iki = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_hazir", hazir, 0);
    chk("rst_mesgul", mesgul, 0);
    chk("rst_tamam", tamam, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_hazir", hazir, 1);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Back-to-back 0xA5 then 0x3C, P=3, even parity, two stop bits
    bits_a = 12'hD4A;
    bits_b = 12'hC78;
    pulses = 0;
    veri = 8'hA5; bolucu = 16'd3; parite_en = 1'b1; parite_tek = 1'b0; dur_iki = 1'b1;
    gecerli = 1'b1;
    #1 chk("b2b_hazir_pre", hazir, 1);
    @(posedge clk);
    for (int c = 1; c <= 72; c++) begin
      @(negedge clk);
      if (c == 1) veri = 8'h3C;
      if (c == 37) gecerli = 1'b0;
      if (c <= 36) chk($sformatf("b2b_tx_c%0d", c), tx, bits_a[(c-1)/3]);
      else         chk($sformatf("b2b_tx_c%0d", c), tx, bits_b[(c-37)/3]);
      chk($sformatf("b2b_mesgul_c%0d", c), mesgul, 1);
      chk($sformatf("b2b_tamam_c%0d", c), tamam, (c == 36 || c == 72));
      if (c == 36) chk("b2b_hazir_c36", hazir, 1);
      if (tamam) pulses++;
    end
    @(negedge clk);
    chk("b2b_pulses", pulses, 2);
    chk("b2b_idle_mesgul", mesgul, 0);
    chk("b2b_idle_tx", tx, 1);

    // Mid-frame config change: frame keeps P=4, no accept while disabled
    bits_c = 12'h2AA;
    veri = 8'h55; bolucu = 16'd4; parite_en = 1'b0; parite_tek = 1'b0; dur_iki = 1'b0;
    gecerli = 1'b1;
    #1 chk("chg_hazir_pre", hazir, 1);
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) gecerli = 1'b0;
      if (c == 5) begin
        tx_en = 1'b0; bolucu = 16'd10; parite_en = 1'b1; dur_iki = 1'b1;
      end
      chk($sformatf("chg_tx_c%0d", c), tx, bits_c[(c-1)/4]);
      chk($sformatf("chg_tamam_c%0d", c), tamam, (c == 40));
    end
    gecerli = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("chg_dis_hazir_%0d", c), hazir, 0);
      chk($sformatf("chg_dis_mesgul_%0d", c), mesgul, 0);
      chk($sformatf("chg_dis_tx_%0d", c), tx, 1);
    end
    gecerli = 1'b0;
    tx_en = 1'b1;

    // Reset during data bit 3 of 0x00 at P=8 (cycles 33..40)
    veri = 8'h00; bolucu = 16'd8; parite_en = 1'b0; parite_tek = 1'b0; dur_iki = 1'b0;
    @(negedge clk);
    gecerli = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 1) gecerli = 1'b0;
    end
    chk("rmf_tx_before", tx, 0);
    chk("rmf_mesgul_before", mesgul, 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rmf_tx_async", tx, 1);
    chk("rmf_mesgul_async", mesgul, 0);
    chk("rmf_tamam_async", tamam, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rmf_mesgul_%0d", c), mesgul, 0);
      chk($sformatf("rmf_tamam_%0d", c), tamam, 0);
      chk($sformatf("rmf_tx_%0d", c), tx, 1);
    end
    chk("rmf_hazir", hazir, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
